// File: rtl/proj_tile_engine.sv
// rtl/proj_tile_engine.sv - tiled OUT = A x W[sel] + bias projection engine with local N x N accumulator
// Define PROJ_SAT_EN to make every MAC and BIAS addition saturate instead of wrapping.
module proj_tile_engine #(
  parameter int N         = 4,
  parameter int ACC_W     = 32,
  parameter int K_TILES   = 32,
  parameter int COL_TILES = 32,
  parameter int ROW_TILES = 1,
  parameter int NUM_SEL   = 3,
  parameter int IN_AW     = 5,
  parameter int W_AW      = 12,
  parameter int OUT_AW    = 7,
  localparam int MEM_W    = N * N * 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             sel,
  input  logic [MEM_W-1:0]       bias,
  output logic                   busy,
  output logic                   done,
  output logic                   tile_valid,
  output logic [N*N*ACC_W-1:0]   tile_out,
  input  logic [MEM_W-1:0]       in_dout,
  output logic                   in_ceb,
  output logic                   in_wen,
  output logic [IN_AW-1:0]       in_addr,
  input  logic [MEM_W-1:0]       w_dout,
  output logic                   w_ceb,
  output logic                   w_wen,
  output logic [W_AW-1:0]        w_addr,
  output logic [MEM_W-1:0]       out_din,
  output logic                   out_ceb,
  output logic                   out_wen,
  output logic [OUT_AW-1:0]      out_addr
);

  localparam int BEATS = ACC_W / 8;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K_TILES > 1) ? $clog2(K_TILES) : 1;
  localparam int CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
  localparam int RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [NW-1:0] MAC_LAST  = NW'(N - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(K_TILES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COL_TILES - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_TILES - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_MAC, S_BIAS, S_WRITE} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               sel_q, sel_d;
  logic [MEM_W-1:0]         bias_q, bias_d, a_q, a_d, w_q, w_d;
  logic [RW-1:0]            r_q, r_d;
  logic [CW-1:0]            j_q, j_d;
  logic [KW-1:0]            k_q, k_d;
  logic [NW-1:0]            c_q, c_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [OUT_AW-1:0]        out_addr_q, out_addr_d;
  logic signed [ACC_W-1:0]  acc_q [N*N];
  logic signed [ACC_W-1:0]  acc_d [N*N];

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] x,
                                                      input logic signed [ACC_W-1:0] y);
`ifdef PROJ_SAT_EN
    logic signed [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (s[ACC_W] != s[ACC_W-1])
      acc_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_add = s[ACC_W-1:0];
`else
    acc_add = x + y;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      bias_q     <= '0;
      a_q        <= '0;
      w_q        <= '0;
      r_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      c_q        <= '0;
      beat_q     <= '0;
      out_addr_q <= '0;
      for (int e = 0; e < N*N; e++) acc_q[e] <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      bias_q     <= bias_d;
      a_q        <= a_d;
      w_q        <= w_d;
      r_q        <= r_d;
      j_q        <= j_d;
      k_q        <= k_d;
      c_q        <= c_d;
      beat_q     <= beat_d;
      out_addr_q <= out_addr_d;
      for (int e = 0; e < N*N; e++) acc_q[e] <= acc_d[e];
    end
  end

  always_comb begin : next_state
    logic signed [7:0]  av, wv, bv;
    logic signed [15:0] prod;
    state_d    = state_q;
    sel_d      = sel_q;
    bias_d     = bias_q;
    a_d        = a_q;
    w_d        = w_q;
    r_d        = r_q;
    j_d        = j_q;
    k_d        = k_q;
    c_d        = c_q;
    beat_d     = beat_q;
    out_addr_d = out_addr_q;
    acc_d      = acc_q;
    av         = '0;
    wv         = '0;
    bv         = '0;
    prod       = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d      = (int'(sel) < NUM_SEL) ? sel : 2'd0;
          bias_d     = bias;
          r_d        = '0;
          j_d        = '0;
          k_d        = '0;
          out_addr_d = '0;
          for (int e = 0; e < N*N; e++) acc_d[e] = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CAPT;
      S_CAPT: begin
        a_d     = in_dout;
        w_d     = w_dout;
        c_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        // One rank-1 update per cycle: column c of A against row c of W.
        for (int i = 0; i < N; i++) begin
          for (int jj = 0; jj < N; jj++) begin
            av   = a_q[(i*N + int'(c_q))*8 +: 8];
            wv   = w_q[(int'(c_q)*N + jj)*8 +: 8];
            prod = av * wv;
            acc_d[i*N+jj] = acc_add(acc_q[i*N+jj], ACC_W'(prod));
          end
        end
        if (c_q == MAC_LAST) begin
          if (k_q == K_LAST) begin
            state_d = S_BIAS;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      S_BIAS: begin
        for (int e = 0; e < N*N; e++) begin
          bv       = bias_q[e*8 +: 8];
          acc_d[e] = acc_add(acc_q[e], ACC_W'(bv));
        end
        beat_d  = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        out_addr_d = out_addr_q + 1'b1;
        if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          if (r_q == ROW_LAST && j_q == COL_LAST) begin
            state_d = S_IDLE;
          end else begin
            if (j_q == COL_LAST) begin
              j_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
            k_d = '0;
            for (int e = 0; e < N*N; e++) acc_d[e] = '0;
            state_d = S_FETCH;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tile_out = '0;
    for (int e = 0; e < N*N; e++) tile_out[e*ACC_W +: ACC_W] = acc_q[e];
  end

  // Strobes decode straight from the state flop so reset forces them inactive at once.
  assign busy       = (state_q != S_IDLE);
  assign in_ceb     = (state_q != S_FETCH);
  assign w_ceb      = (state_q != S_FETCH);
  assign in_wen     = 1'b1;
  assign w_wen      = 1'b1;
  assign out_ceb    = (state_q != S_WRITE);
  assign out_wen    = (state_q != S_WRITE);
  assign tile_valid = (state_q == S_WRITE) && (beat_q == '0);
  assign done       = (state_q == S_WRITE) && (beat_q == BEAT_LAST) &&
                      (r_q == ROW_LAST) && (j_q == COL_LAST);
  assign out_din    = tile_out[beat_q*MEM_W +: MEM_W];
  assign out_addr   = out_addr_q;
  assign in_addr    = IN_AW'(32'(r_q) * K_TILES + 32'(k_q));
  assign w_addr     = W_AW'(32'(sel_q) * K_TILES * COL_TILES + 32'(k_q) * COL_TILES + 32'(j_q));

endmodule

// File: tb/tb_proj_tile_engine.sv
// tb/tb_proj_tile_engine.sv - directed self-checking bench for proj_tile_engine
module tb_proj_tile_engine;

  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_: 1x1x1 tile config, k_: K_TILES=2, d_: defaults, o_: ACC_W=16
  logic         s_start, k_start, d_start, o_start;
  logic [1:0]   s_sel, k_sel, d_sel, o_sel;
  logic [127:0] s_bias, k_bias, d_bias, o_bias;
  logic         s_busy, k_busy, d_busy, o_busy;
  logic         s_done, k_done, d_done, o_done;
  logic         s_tv, k_tv, d_tv, o_tv;
  logic [511:0] s_tile, k_tile, d_tile;
  logic [255:0] o_tile;
  logic [127:0] s_in_dout, k_in_dout, d_in_dout, o_in_dout;
  logic [127:0] s_w_dout, k_w_dout, d_w_dout, o_w_dout;
  logic         s_in_ceb, k_in_ceb, d_in_ceb, o_in_ceb;
  logic         s_in_wen, k_in_wen, d_in_wen, o_in_wen;
  logic         s_w_ceb, k_w_ceb, d_w_ceb, o_w_ceb;
  logic         s_w_wen, k_w_wen, d_w_wen, o_w_wen;
  logic [4:0]   s_in_addr, k_in_addr, d_in_addr, o_in_addr;
  logic [11:0]  s_w_addr, k_w_addr, d_w_addr, o_w_addr;
  logic [127:0] s_out_din, k_out_din, d_out_din, o_out_din;
  logic         s_out_ceb, k_out_ceb, d_out_ceb, o_out_ceb;
  logic         s_out_wen, k_out_wen, d_out_wen, o_out_wen;
  logic [6:0]   s_out_addr, k_out_addr, d_out_addr, o_out_addr;

  logic [127:0] sa, sw, ones, negs;

  proj_tile_engine #(.N(4), .ACC_W(32), .K_TILES(1), .COL_TILES(1), .ROW_TILES(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sel(s_sel), .bias(s_bias), .busy(s_busy),
    .done(s_done), .tile_valid(s_tv), .tile_out(s_tile), .in_dout(s_in_dout), .in_ceb(s_in_ceb),
    .in_wen(s_in_wen), .in_addr(s_in_addr), .w_dout(s_w_dout), .w_ceb(s_w_ceb), .w_wen(s_w_wen),
    .w_addr(s_w_addr), .out_din(s_out_din), .out_ceb(s_out_ceb), .out_wen(s_out_wen),
    .out_addr(s_out_addr));

  proj_tile_engine #(.N(4), .ACC_W(32), .K_TILES(2), .COL_TILES(1), .ROW_TILES(1)) u_k (
    .clk(clk), .rst_n(rst_n), .start(k_start), .sel(k_sel), .bias(k_bias), .busy(k_busy),
    .done(k_done), .tile_valid(k_tv), .tile_out(k_tile), .in_dout(k_in_dout), .in_ceb(k_in_ceb),
    .in_wen(k_in_wen), .in_addr(k_in_addr), .w_dout(k_w_dout), .w_ceb(k_w_ceb), .w_wen(k_w_wen),
    .w_addr(k_w_addr), .out_din(k_out_din), .out_ceb(k_out_ceb), .out_wen(k_out_wen),
    .out_addr(k_out_addr));

  proj_tile_engine u_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .sel(d_sel), .bias(d_bias), .busy(d_busy),
    .done(d_done), .tile_valid(d_tv), .tile_out(d_tile), .in_dout(d_in_dout), .in_ceb(d_in_ceb),
    .in_wen(d_in_wen), .in_addr(d_in_addr), .w_dout(d_w_dout), .w_ceb(d_w_ceb), .w_wen(d_w_wen),
    .w_addr(d_w_addr), .out_din(d_out_din), .out_ceb(d_out_ceb), .out_wen(d_out_wen),
    .out_addr(d_out_addr));

  proj_tile_engine #(.N(4), .ACC_W(16), .K_TILES(1), .COL_TILES(1), .ROW_TILES(1)) u_o (
    .clk(clk), .rst_n(rst_n), .start(o_start), .sel(o_sel), .bias(o_bias), .busy(o_busy),
    .done(o_done), .tile_valid(o_tv), .tile_out(o_tile), .in_dout(o_in_dout), .in_ceb(o_in_ceb),
    .in_wen(o_in_wen), .in_addr(o_in_addr), .w_dout(o_w_dout), .w_ceb(o_w_ceb), .w_wen(o_w_wen),
    .w_addr(o_w_addr), .out_din(o_out_din), .out_ceb(o_out_ceb), .out_wen(o_out_wen),
    .out_addr(o_out_addr));

  // Memories with 1-cycle read latency; data is only valid the cycle after a read.
  always @(posedge clk) begin
    s_in_dout <= !s_in_ceb ? sa   : '0;
    s_w_dout  <= !s_w_ceb  ? sw   : '0;
    k_in_dout <= !k_in_ceb ? ones : '0;
    k_w_dout  <= !k_w_ceb  ? ones : '0;
    o_in_dout <= !o_in_ceb ? negs : '0;
    o_w_dout  <= !o_w_ceb  ? negs : '0;
    d_in_dout <= '0;
    d_w_dout  <= '0;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ident_beat(input int b);
    logic [127:0] v;
    v = '0;
    for (int e = 0; e < 4; e++) v[e*32 +: 32] = 32'(4*b + e + 1);
    return v;
  endfunction

  logic [127:0] sm_beats [4];
  int sm_tv, sm_done, sm_nwr, sm_fetch, sm_nfetch, sm_ndone;
  logic [11:0] sm_waddr;

  task automatic small_job(input bit pulse_busy);
    for (int b = 0; b < 4; b++) sm_beats[b] = '0;
    sm_tv = -1; sm_done = -1; sm_nwr = 0; sm_fetch = -1; sm_nfetch = 0; sm_ndone = 0;
    sm_waddr = '1;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (pulse_busy && cyc == 4) begin s_start = 1'b1; s_sel = 2'd2; end
      if (pulse_busy && cyc == 5) s_start = 1'b0;
      if (!s_in_ceb) begin
        if (sm_fetch < 0) begin sm_fetch = cyc; sm_waddr = s_w_addr; end
        sm_nfetch++;
      end
      if (s_tv) sm_tv = cyc;
      if (s_done) begin sm_done = cyc; sm_ndone++; end
      if (!s_out_ceb && !s_out_wen) begin
        if (sm_nwr < 4) sm_beats[sm_nwr] = s_out_din;
        sm_nwr++;
      end
    end
  endtask

  task automatic chk_small(input string tag, input logic [11:0] exp_waddr);
    check({tag, ".fetch_cyc"}, sm_fetch, 1);
    check({tag, ".nfetch"}, sm_nfetch, 1);
    check({tag, ".w_addr"}, sm_waddr, exp_waddr);
    check({tag, ".tile_valid_cyc"}, sm_tv, 8);
    check({tag, ".done_cyc"}, sm_done, 11);
    check({tag, ".ndone"}, sm_ndone, 1);
    check({tag, ".nwrites"}, sm_nwr, 4);
    for (int b = 0; b < 4; b++) check({tag, ".beat"}, sm_beats[b], ident_beat(b));
  endtask

  initial begin
    int rcs [2];
    int nf, nw, bad_w, bad_i, bad_o, ndone, done_cyc, kk, t;
    logic [11:0] wa0, wa1, wa31, wa32;
    logic [4:0] ka [2];
    logic [127:0] kb [4];
    logic [127:0] ob [2];
    logic [127:0] o_exp;
    bit seen;

    rst_n = 1'b0;
    s_start = 0; k_start = 0; d_start = 0; o_start = 0;
    s_sel = 2'd3; k_sel = 2'd0; d_sel = 2'd2; o_sel = 2'd0;
    s_bias = '0; d_bias = '0; o_bias = '0;
    k_bias = {16{8'hFD}};
    sa = '0; sw = '0;
    for (int i = 0; i < 4; i++) sa[(i*4+i)*8 +: 8] = 8'd1;
    for (int e = 0; e < 16; e++) sw[e*8 +: 8] = 8'(e + 1);
    ones = {16{8'h01}};
    negs = {16{8'h80}};

    repeat (2) @(negedge clk);
    check("rst.busy", s_busy, 0);
    check("rst.ceb_wen", {s_in_ceb, s_w_ceb, s_out_ceb, s_out_wen, s_in_wen, s_w_wen}, 6'b111111);
    check("rst.pulses", {s_done, s_tv}, 2'b00);
    check("rst.tile_out", s_tile[127:0], '0);
    check("rst.addrs", {d_w_addr, d_in_addr, d_out_addr}, '0);
    rst_n = 1'b1;

    // sel=3 is out of range and must address weight set 0
    small_job(0);
    chk_small("ident", 12'd0);

    s_sel = 2'd1;
    small_job(1);
    chk_small("pulse", 12'd1);

    rcs = '{4, 9};
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      s_start = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b0;
      repeat (rcs[n]) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.busy", s_busy, 0);
      check("midrst.ceb_wen", {s_in_ceb, s_w_ceb, s_out_ceb, s_out_wen}, 4'b1111);
      check("midrst.pulses", {s_done, s_tv}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
    end
    s_sel = 2'd0;
    small_job(0);
    chk_small("post_rst", 12'd0);

    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      if (cyc == 11) check("held.done", s_done, 1);
      if (cyc == 12) check("held.idle_busy", s_busy, 0);
      if (cyc == 13) begin
        check("held.refetch", {s_busy, s_in_ceb}, 2'b10);
        s_start = 1'b0;
      end
    end
    seen = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (s_done) seen = 1;
    end
    check("held.second_done", seen, 1);

    // K_TILES=2: all ones and bias -3 gives 8 - 3 = 5 everywhere
    nf = 0; nw = 0; done_cyc = -1;
    ka = '{5'h1f, 5'h1f};
    for (int b = 0; b < 4; b++) kb[b] = '0;
    @(negedge clk);
    k_start = 1'b1;
    @(posedge clk);
    #1 k_start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (!k_in_ceb) begin if (nf < 2) ka[nf] = k_in_addr; nf++; end
      if (!k_out_ceb && !k_out_wen) begin if (nw < 4) kb[nw] = k_out_din; nw++; end
      if (k_done) done_cyc = cyc;
    end
    check("k2.nfetch", nf, 2);
    check("k2.in_addr0", ka[0], 0);
    check("k2.in_addr1", ka[1], 1);
    check("k2.nwrites", nw, 4);
    check("k2.done_cyc", done_cyc, 17);
    for (int b = 0; b < 4; b++) check("k2.beat", kb[b], {4{32'd5}});

    // Default geometry, sel=2: full 32-tile job
    nf = 0; nw = 0; bad_w = 0; bad_i = 0; bad_o = 0; ndone = 0; done_cyc = -1;
    wa0 = '0; wa1 = '0; wa31 = '0; wa32 = '0;
    @(negedge clk);
    d_start = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
    for (int cyc = 1; cyc <= 6400; cyc++) begin
      @(negedge clk);
      if (d_in_ceb != d_w_ceb) bad_i++;
      if (!d_w_ceb) begin
        kk = nf % 32;
        t  = nf / 32;
        if (d_w_addr != 12'(2048 + kk*32 + t)) bad_w++;
        if (d_in_addr != 5'(kk)) bad_i++;
        if (nf == 0)  wa0  = d_w_addr;
        if (nf == 1)  wa1  = d_w_addr;
        if (nf == 31) wa31 = d_w_addr;
        if (nf == 32) wa32 = d_w_addr;
        nf++;
      end
      if (!d_out_ceb && !d_out_wen) begin
        if (d_out_addr != 7'(nw)) bad_o++;
        nw++;
      end
      if (d_done) begin ndone++; done_cyc = cyc; end
    end
    check("def.nfetch", nf, 1024);
    check("def.w_addr_first", wa0, 2048);
    check("def.w_addr_second", wa1, 2080);
    check("def.w_addr_tile0_last", wa31, 3040);
    check("def.w_addr_tile1_first", wa32, 2049);
    check("def.w_addr_bad", bad_w, 0);
    check("def.in_addr_bad", bad_i, 0);
    check("def.nwrites", nw, 128);
    check("def.out_addr_bad", bad_o, 0);
    check("def.ndone", ndone, 1);
    check("def.done_cyc", done_cyc, 6304);

    // ACC_W=16 overflow: four products of 16384 sum to 65536
`ifdef PROJ_SAT_EN
    o_exp = {8{16'h7fff}};
`else
    o_exp = '0;
`endif
    nw = 0; done_cyc = -1;
    ob = '{'1, '1};
    @(negedge clk);
    o_start = 1'b1;
    @(posedge clk);
    #1 o_start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (!o_out_ceb && !o_out_wen) begin if (nw < 2) ob[nw] = o_out_din; nw++; end
      if (o_done) done_cyc = cyc;
    end
    check("ovf.nwrites", nw, 2);
    check("ovf.done_cyc", done_cyc, 9);
    check("ovf.beat0", ob[0], o_exp);
    check("ovf.beat1", ob[1], o_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
